rx_packet_control_module: RTL
=============================

# rx_packet_control_module

Packet-level controller for the UART receive path. It sequences `Rx_module` through its enable/done handshake and assembles received bytes into framed packets: header, length, payload and checksum. Valid payloads are held in an internal buffer for a downstream consumer until acknowledged. It replaces the single-byte `control_module` wherever multi-byte commands arrive over RS232.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum payload bytes, range 1..15.
- `HEADER`, 8'hAA: start-of-frame byte.
- `TIMEOUT`, 50000: inter-byte timeout in CLK cycles (1 ms at 50 MHz).

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: system clock.
- `RSTn` in 1: asynchronous active-low reset.
- `RX_Done_Sig` in 1: one-cycle pulse from `Rx_module`; `RX_Data` is valid in that cycle.
- `RX_Data` in 8: received byte.
- `RX_En_Sig` out 1: enable to `Rx_module`.
- `Pkt_Valid_Sig` out 1: a good packet is held in the buffer.
- `Pkt_Len` out 4: payload length of the held packet.
- `Rd_Addr` in 4: buffer read index.
- `Rd_Data` out 8: buffer byte at `Rd_Addr`, combinational. Returns 0 when `Rd_Addr >= MAX_LEN`.
- `Pkt_Ack_Sig` in 1: one-cycle pulse from the consumer that releases the buffer.
- `Err_Sig` out 1: one-cycle error pulse.
- `Err_Code` out 2: error type. 01 = bad length, 10 = bad checksum, 11 = timeout. Holds its last value between pulses.

## Operation
- The frame is `HEADER`, LEN, LEN payload bytes, CSUM.
- CSUM = (LEN + sum of payload bytes) mod 256, computed in an 8-bit wrapping accumulator.
- States and transitions:
  - IDLE: `RX_En_Sig`=1. A received byte equal to `HEADER` goes to LEN. Any other byte is discarded and the block stays in IDLE.
  - LEN: a byte of 1..MAX_LEN is latched into the length register, the accumulator is set to that byte, the index is set to 0, and the block goes to PAYLOAD. A byte of 0 or greater than MAX_LEN raises the bad-length error and returns to IDLE.
  - PAYLOAD: each byte is written to buffer[index], added to the accumulator, and the index increments. After the byte at index LEN-1, the block goes to CSUM.
  - CSUM: if the byte equals the accumulator, the block goes to HOLD. Otherwise it raises the bad-checksum error and returns to IDLE.
  - HOLD: `Pkt_Valid_Sig`=1 and `RX_En_Sig`=0, which backpressures the receiver. `Pkt_Ack_Sig` returns the block to IDLE.
- Byte handshake: in the cycle after any sampled `RX_Done_Sig`, `RX_En_Sig` is 0 for exactly one cycle. It then returns to 1 unless the block is in HOLD.
- Inter-byte timeout:
  - Active only in LEN, PAYLOAD and CSUM.
  - The counter clears on entering those states and on every sampled `RX_Done_Sig`.
  - When the counter reaches TIMEOUT-1 with no Done, the block raises the timeout error and returns to IDLE.
  - The counter saturates and never wraps.
- The buffer is overwritten only by the next packet. `Pkt_Len` and buffer contents are stable throughout HOLD.
- `Pkt_Ack_Sig` outside HOLD is ignored.
- `RX_Done_Sig` in HOLD is ignored; it cannot occur while the enable is low.

## Timing
- Reset values:
  - `RX_En_Sig`=0, `Pkt_Valid_Sig`=0, `Pkt_Len`=0, `Err_Sig`=0, `Err_Code`=00.
  - Buffer cleared to 0, state IDLE.
  - `RX_En_Sig` rises on the first clock edge after reset deasserts.
- `RX_Done_Sig` sampled at edge t:
  - The state update is visible after edge t.
  - `RX_En_Sig`=0 during cycle t+1.
- `Pkt_Valid_Sig` rises in the cycle after the good CSUM byte's Done. Latency from CSUM Done to valid is 1 cycle.
- Error pulse timing:
  - `Err_Sig`/`Err_Code` update in the cycle after the offending Done.
  - For timeout, they update in the cycle after the counter reaches TIMEOUT-1.
- Ack sampled at edge t: `Pkt_Valid_Sig`=0 and `RX_En_Sig`=1 from cycle t+1.
- Simultaneous Done and timeout expiry: Done wins and no error is raised.
- Reset mid-packet discards the partial frame immediately and asynchronously.

## Test plan
- Reset release: check `RX_En_Sig` 0→1 one cycle after `RSTn` rises. All other outputs must read 0.
- Good frame AA 03 11 22 33 69: check `Pkt_Valid_Sig`=1, `Pkt_Len`=3, and Rd_Addr 0/1/2 → 11/22/33. `RX_En_Sig` stays 0 until `Pkt_Ack_Sig`, then returns to 1 and `Pkt_Valid_Sig` falls.
- Bad checksum AA 02 10 20 00: check `Err_Sig` pulse with `Err_Code`=10 and no valid. A following good frame AA 01 05 06 is accepted.
- Bad length AA 00 and AA 10 (with MAX_LEN=8): each gives `Err_Code`=01. Later bytes are treated as IDLE garbage until the next AA.
- Timeout with TIMEOUT=100: send AA 02 11, then idle 100 cycles. Check `Err_Code`=11 exactly at cycle 100. Also drive Done on the expiry cycle and check that no error is raised.
- Garbage and handshake: send 55 00 AA 01 FF 00 and check the packet holds FF with sum 00 wrapping mod 256. Assert `RX_En_Sig` low for exactly one cycle after every Done, and assert `RSTn` low mid-PAYLOAD clears the state.

Source files
------------

// File: rtl/rx_packet_control_module.sv
// -----------------------------------------------------------------------------
// rx_packet_control_module
//
// Packet-level controller for the UART receive path. Drives the Rx_module
// enable/done handshake and assembles received bytes into frames of the form
//   HEADER, LEN, LEN payload bytes, CSUM
// where CSUM = (LEN + sum of payload) mod 256. A good payload is held in an
// internal buffer (with receive backpressure) until the consumer acknowledges.
//
// Ports:
//   CLK            in   system clock
//   RSTn           in   asynchronous active-low reset
//   RX_Done_Sig    in   one-cycle byte-received pulse from Rx_module
//   RX_Data        in   received byte, valid with RX_Done_Sig
//   RX_En_Sig      out  enable to Rx_module (low one cycle after each byte,
//                       low throughout HOLD)
//   Pkt_Valid_Sig  out  a good packet is held in the buffer
//   Pkt_Len        out  payload length of the held packet
//   Rd_Addr        in   buffer read index
//   Rd_Data        out  buffer byte at Rd_Addr (combinational, 0 if out of range)
//   Pkt_Ack_Sig    in   one-cycle pulse releasing the held packet
//   Err_Sig        out  one-cycle error pulse
//   Err_Code       out  01 bad length, 10 bad checksum, 11 timeout (sticky)
// -----------------------------------------------------------------------------
module rx_packet_control_module #(
  parameter int         MAX_LEN = 8,
  parameter logic [7:0] HEADER  = 8'hAA,
  parameter int         TIMEOUT = 50000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX_Done_Sig,
  input  logic [7:0] RX_Data,
  output logic       RX_En_Sig,
  output logic       Pkt_Valid_Sig,
  output logic [3:0] Pkt_Len,
  input  logic [3:0] Rd_Addr,
  output logic [7:0] Rd_Data,
  input  logic       Pkt_Ack_Sig,
  output logic       Err_Sig,
  output logic [1:0] Err_Code
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [MAX_LEN*8-1:0] buf_flat;

  logic done_s;
  logic timed_s;
  logic expire_s;
  logic len_ok_s;
  logic last_byte_s;
  logic buf_wr_s;

  // Done pulses are meaningless while the receiver is held off in HOLD.
  assign done_s      = RX_Done_Sig && (state_q != S_HOLD);
  assign timed_s     = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  // A Done on the expiry cycle wins over the timeout.
  assign expire_s    = timed_s && !done_s && (cnt_q == CNT_LAST);
  assign len_ok_s    = (RX_Data != 8'd0) && (RX_Data <= MAX_LEN_B);
  assign last_byte_s = (idx_q == (len_q - 4'd1));
  assign buf_wr_s    = done_s && (state_q == S_PAYLOAD);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (including error reporting and handshake enable)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    code_d  = code_q;

    case (state_q)
      S_IDLE: begin
        if (done_s && (RX_Data == HEADER)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (expire_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else if (done_s) begin
          if (len_ok_s) begin
            state_d = S_PAYLOAD;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end
        end
      end

      S_PAYLOAD: begin
        if (expire_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else if (done_s && last_byte_s) begin
          state_d = S_CSUM;
        end
      end

      S_CSUM: begin
        if (expire_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else if (done_s) begin
          if (RX_Data == acc_q) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end
      end

      S_HOLD: begin
        if (Pkt_Ack_Sig) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Enable drops for one cycle after every accepted byte and stays low
    // while a packet is held.
    en_d = !done_s && (state_d != S_HOLD);
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    RX_En_Sig     = en_q;
    Pkt_Valid_Sig = (state_q == S_HOLD);
    Pkt_Len       = len_q;
    Err_Sig       = err_q;
    Err_Code      = code_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath: length, payload index, checksum accumulator, inter-byte timer
  // ---------------------------------------------------------------------------
  always_comb begin
    len_d = len_q;
    idx_d = idx_q;
    acc_d = acc_q;

    if (done_s && (state_q == S_LEN) && len_ok_s) begin
      len_d = RX_Data[3:0];
      acc_d = RX_Data;
      idx_d = 4'd0;
    end else if (buf_wr_s) begin
      acc_d = acc_q + RX_Data;
      idx_d = idx_q + 4'd1;
    end

    // Entering a timed state always happens on a Done, so clearing on Done
    // also covers the clear-on-entry rule. The counter saturates at the
    // expiry value rather than wrapping.
    if (done_s || !timed_s) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      len_q <= 4'd0;
      idx_q <= 4'd0;
      acc_q <= 8'd0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload buffer: one register per entry so it can be cleared on reset and
  // read asynchronously.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_buf
      logic [7:0] byte_q;

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          byte_q <= 8'd0;
        end else if (buf_wr_s && (idx_q == 4'(gi))) begin
          byte_q <= RX_Data;
        end
      end

      assign buf_flat[gi*8 +: 8] = byte_q;
    end
  endgenerate

  // Out-of-range addresses match no entry and read as zero.
  always_comb begin
    Rd_Data = 8'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (Rd_Addr == 4'(i)) begin
        Rd_Data = buf_flat[i*8 +: 8];
      end
    end
  end

endmodule
